seq_frame_tx: RTL



---
 rtl/seq_frame_tx.sv | 114 +++++++++++
 1 files changed

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: a preamble of ones, a separator zero, then the payload MSB first.
// A zero is stuffed after every STUFF_RUN consecutive payload ones so that only the preamble forms a long run.
module seq_frame_tx #(
   parameter int DATA_W    = 8,
   parameter int PRE_LEN   = 4,
   parameter int STUFF_RUN = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] data,
   output logic              x,
   output logic              busy,
   output logic              done,
   output logic [2:0]        state
);

   localparam int PCW = $clog2(PRE_LEN + 1);
   localparam int RCW = $clog2(STUFF_RUN + 1);
   localparam int BCW = $clog2(DATA_W + 1);
   localparam logic [PCW-1:0] PRE_LAST = PCW'(PRE_LEN - 1);
   localparam logic [RCW-1:0] RUN_MAX  = RCW'(STUFF_RUN);
   localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_W - 1);
   localparam logic [BCW-1:0] BIT_ALL  = BCW'(DATA_W);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PRE   = 3'd1,
      SEP   = 3'd2,
      DATA  = 3'd3,
      STUFF = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] sr_q, sr_d;
   logic [PCW-1:0]    pre_q, pre_d;
   logic [RCW-1:0]    run_q, run_d;
   logic [BCW-1:0]    bit_q, bit_d;
   logic              x_q, x_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      pre_d   = pre_q;
      run_d   = run_q;
      bit_d   = bit_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               sr_d    = data;
               pre_d   = '0;
               run_d   = '0;
               state_d = PRE;
            end
         end
         PRE: begin
            pre_d = pre_q + 1'b1;
            if (pre_q == PRE_LAST) state_d = SEP;
         end
         SEP: begin
            bit_d   = '0;
            state_d = DATA;
         end
         DATA: begin
            // The bit is consumed even when a stuff follows, so STUFF can tell whether any remain.
            sr_d  = sr_q << 1;
            bit_d = bit_q + 1'b1;
            run_d = sr_q[DATA_W-1] ? run_q + 1'b1 : '0;
            if (sr_q[DATA_W-1] && run_d == RUN_MAX) state_d = STUFF;
            else if (bit_q == BIT_LAST)             state_d = IDLE;
         end
         STUFF: begin
            run_d   = '0;
            state_d = (bit_q == BIT_ALL) ? IDLE : DATA;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are derived from the next state so they are registered alongside it.
      x_d    = (state_d == PRE) || ((state_d == DATA) && sr_d[DATA_W-1]);
      busy_d = (state_d != IDLE);
      done_d = (state_d == IDLE) && ((state_q == DATA) || (state_q == STUFF));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         sr_q    <= '0;
         pre_q   <= '0;
         run_q   <= '0;
         bit_q   <= '0;
         x_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         pre_q   <= pre_d;
         run_q   <= run_d;
         bit_q   <= bit_d;
         x_q     <= x_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign x     = x_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign state = state_q;

endmodule
